instruction_fetch: RTL and testbench

Dual-issue fetch stage; the writer side of the IF/ID pipeline register. It maintains the fetch PC and issues doubleword (instruction-pair) read requests to local store. Returned pairs are buffered in a small FIFO and presented to IF/ID with their PC+8. It handles decode back-pressure and branch redirects, including discard of in-flight reads.

---
 rtl/spu_fetch_pkg.sv | 18 +
 rtl/fetch_pair_fifo.sv | 68 ++++++
 rtl/instruction_fetch.sv | 132 +++++++++++++
 tb/tb_instruction_fetch.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/spu_fetch_pkg.sv
// Shared types and constants for the SPU dual-issue fetch stage.
package spu_fetch_pkg;

  // Widest fetch PC any instance may use; narrower instances zero-extend into entries.
  localparam int unsigned FETCH_PC_BITS = 32;
  localparam int unsigned INSTR_BITS    = 32;
  localparam int unsigned PAIR_BYTES    = 8;

  localparam logic [INSTR_BITS-1:0] NOP_INSTR = 32'h4020_0000;

  // One buffered instruction pair and the byte address of its first word.
  typedef struct packed {
    logic [FETCH_PC_BITS-1:0] pc;
    logic [INSTR_BITS-1:0]    instr1;
    logic [INSTR_BITS-1:0]    instr2;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_pair_fifo.sv
// Synchronous FIFO of instruction pairs.
// Ports: clk, rst_n (sync, active-low), flush (empties the FIFO, wins over
// push/pop), push/push_data, pop, head (entry at the read pointer), count, empty.
// Push and pop may coincide when full or empty; push while full without pop is illegal.
module fetch_pair_fifo
  import spu_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   cnt;
  logic            full;
  logic            do_push;
  logic            do_pop;

  // Pop only real data; a push is accepted when a slot is free or one frees this cycle.
  always_comb begin
    full    = (cnt == CW'(DEPTH));
    empty   = (cnt == '0);
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    head    = mem[rd_ptr];
    count   = cnt;
  end

  // Pointer and occupancy state; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && do_push) mem[wr_ptr] <= push_data;
  end

  // Credit logic upstream must make overflow impossible.
  always @(posedge clk) begin
    if (rst_n && !flush) begin
      assert (!(push && full && !pop))
        else $error("fetch_pair_fifo: push while full");
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Dual-issue fetch stage: writer side of the IF/ID register.
// Ports:
//   clk, rst_n          clock and synchronous active-low reset
//   ls_req/ls_addr      pair read request to local store (addr 8-byte aligned)
//   ls_gnt              request accepted this cycle
//   ls_rvalid/ls_rdata  in-order read response, [63:32] = word at addr
//   branch_taken/target redirect from execute, overrides everything this cycle
//   stall               IF/ID cannot accept this cycle
//   PC_adderOut         pair PC + 8; instruction1/2 the pair; fetch_valid qualifies them
// PCbitsize must not exceed FETCH_PC_BITS.
module instruction_fetch
  import spu_fetch_pkg::*;
#(
  parameter int unsigned          PCbitsize  = 32,
  parameter int unsigned          FIFO_DEPTH = 4,
  parameter logic [PCbitsize-1:0] RESET_PC   = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 ls_req,
  output logic [PCbitsize-1:0] ls_addr,
  input  logic                 ls_gnt,
  input  logic                 ls_rvalid,
  input  logic [63:0]          ls_rdata,
  input  logic                 branch_taken,
  input  logic [PCbitsize-1:0] branch_target,
  input  logic                 stall,
  output logic [PCbitsize-1:0] PC_adderOut,
  output logic [31:0]          instruction1,
  output logic [31:0]          instruction2,
  output logic                 fetch_valid
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SW = CW + 1;

  logic [PCbitsize-1:0] fetch_pc;
  logic [PCbitsize-1:0] push_pc;
  logic [PCbitsize-1:0] redirect_pc;
  logic [CW-1:0]        outstanding;
  logic [CW-1:0]        outstanding_nxt;
  logic [CW-1:0]        drop_cnt;
  logic [CW-1:0]        occupancy;
  logic                 nop_first;
  logic                 grant;
  logic                 drop_rsp;
  logic                 push;
  logic                 pop;
  logic                 fifo_empty;
  fetch_entry_t         push_entry;
  fetch_entry_t         head;
  logic                 unused_target_bits;

  // Byte-lane bits of the target are meaningless for word fetch.
  assign unused_target_bits = ^branch_target[1:0];

  fetch_pair_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (branch_taken),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (occupancy),
    .empty     (fifo_empty)
  );

  // Credit, drop, push/pop and output steering.
  always_comb begin
    ls_req          = 1'b0;
    grant           = 1'b0;
    drop_rsp        = 1'b0;
    push            = 1'b0;
    pop             = 1'b0;
    fetch_valid     = 1'b0;
    PC_adderOut     = '0;
    instruction1    = '0;
    instruction2    = '0;
    redirect_pc     = {branch_target[PCbitsize-1:3], 3'b000};

    // Every in-flight read owns a FIFO slot, so the FIFO can never overflow.
    ls_req   = rst_n & ~branch_taken &
               ((SW'(occupancy) + SW'(outstanding)) < SW'(FIFO_DEPTH));
    ls_addr  = fetch_pc;
    grant    = ls_req & ls_gnt;

    drop_rsp = ls_rvalid & (drop_cnt != '0);
    push     = ls_rvalid & ~drop_rsp & ~branch_taken;
    outstanding_nxt = outstanding + CW'(grant) - CW'(ls_rvalid);

    push_entry.pc     = FETCH_PC_BITS'(push_pc);
    push_entry.instr1 = nop_first ? NOP_INSTR : ls_rdata[63:32];
    push_entry.instr2 = ls_rdata[31:0];

    fetch_valid = rst_n & ~fifo_empty & ~branch_taken;
    pop         = fetch_valid & ~stall;
    if (fetch_valid) begin
      PC_adderOut  = PCbitsize'(head.pc) + PCbitsize'(PAIR_BYTES);
      instruction1 = head.instr1;
      instruction2 = head.instr2;
    end
  end

  // PC, credit and redirect bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      push_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      nop_first   <= 1'b0;
    end else begin
      outstanding <= outstanding_nxt;
      if (branch_taken) begin
        // Everything still in flight after this cycle belongs to the old path.
        fetch_pc  <= redirect_pc;
        push_pc   <= redirect_pc;
        drop_cnt  <= outstanding_nxt;
        nop_first <= branch_target[2];
      end else begin
        if (grant)    fetch_pc <= fetch_pc + PCbitsize'(PAIR_BYTES);
        if (drop_rsp) drop_cnt <= drop_cnt - CW'(1);
        if (push) begin
          push_pc   <= push_pc + PCbitsize'(PAIR_BYTES);
          nop_first <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: a local-store model answers granted
// reads in order after a random latency; the expected pair stream is derived
// from the current program path (last redirect target or reset PC).
module tb_instruction_fetch;
  import spu_fetch_pkg::*;

  localparam int unsigned PCW   = 32;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RST_PC = 32'h0;

  logic        clk;
  logic        rst_n;
  logic        ls_req;
  logic [31:0] ls_addr;
  logic        ls_gnt;
  logic        ls_rvalid;
  logic [63:0] ls_rdata;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        stall;
  logic [31:0] PC_adderOut;
  logic [31:0] instruction1;
  logic [31:0] instruction2;
  logic        fetch_valid;

  instruction_fetch #(.PCbitsize(PCW), .FIFO_DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ls_req        (ls_req),
    .ls_addr       (ls_addr),
    .ls_gnt        (ls_gnt),
    .ls_rvalid     (ls_rvalid),
    .ls_rdata      (ls_rdata),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .stall         (stall),
    .PC_adderOut   (PC_adderOut),
    .instruction1  (instruction1),
    .instruction2  (instruction2),
    .fetch_valid   (fetch_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc8; logic [31:0] i1; logic [31:0] i2; } exp_t;
  typedef struct { logic [31:0] addr; int due; } rd_t;

  exp_t        exp_q[$];
  rd_t         pend[$];
  logic [31:0] path_pc;
  bit          path_nop;
  logic [31:0] exp_fetch;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          pops = 0;
  int          gnt_pct = 100;
  int          lat_min = 1;
  int          lat_max = 1;
  bit          last_fv;
  bit          mon_en = 1'b0;
  bit          rst_req = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Keep a window of upcoming program-order pairs for the current path.
  function automatic void refill();
    exp_t e;
    while (exp_q.size() < 16) begin
      e.pc8 = path_pc + 32'd8;
      e.i1  = path_nop ? NOP_INSTR : mem_word(path_pc);
      e.i2  = mem_word(path_pc + 32'd4);
      exp_q.push_back(e);
      path_nop = 1'b0;
      path_pc  = path_pc + 32'd8;
    end
  endfunction

  function automatic void new_path(input logic [31:0] tgt);
    exp_q.delete();
    path_pc   = {tgt[31:3], 3'b000};
    path_nop  = tgt[2];
    exp_fetch = {tgt[31:3], 3'b000};
    refill();
  endfunction

  // One clock of stimulus: local-store response, grant, redirect and stall.
  task automatic step(input bit br, input logic [31:0] tgt, input bit st);
    rd_t rd;
    @(negedge clk);
    cyc++;
    rst_n         = rst_req;
    branch_taken  = br;
    branch_target = tgt;
    stall         = st;
    ls_rvalid     = 1'b0;
    ls_rdata      = 64'h0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      rd        = pend.pop_front();
      ls_rvalid = 1'b1;
      ls_rdata  = {mem_word(rd.addr), mem_word(rd.addr + 32'd4)};
    end
    ls_gnt = ($urandom_range(99) < 32'(gnt_pct));
    #1;
    last_fv = fetch_valid;
    if (br) new_path(tgt);
    if (ls_req && ls_gnt) begin
      check("ls_addr", ls_addr, exp_fetch);
      rd.addr = ls_addr;
      rd.due  = cyc + int'($urandom_range(lat_max, lat_min));
      pend.push_back(rd);
      exp_fetch = exp_fetch + 32'd8;
    end
  endtask

  task automatic do_reset();
    rst_req = 1'b0;
    pend.delete();
    repeat (3) step(1'b0, 32'h0, 1'b0);
    check("rst_ls_req", {31'b0, ls_req}, 32'h0);
    check("rst_fetch_valid", {31'b0, fetch_valid}, 32'h0);
    check("rst_outputs", PC_adderOut | instruction1 | instruction2, 32'h0);
    new_path(RST_PC);
    rst_req = 1'b1;
  endtask

  // Monitor: compare the presented pair against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (mon_en) begin
      if (branch_taken) begin
        check("req_during_redirect", {31'b0, ls_req}, 32'h0);
        check("valid_during_redirect", {31'b0, fetch_valid}, 32'h0);
      end
      if (!fetch_valid) begin
        check("idle_outputs_zero", PC_adderOut | instruction1 | instruction2, 32'h0);
      end else begin
        e = exp_q[0];
        if (!stall) begin
          void'(exp_q.pop_front());
          pops++;
          refill();
        end
        check("PC_adderOut", PC_adderOut, e.pc8);
        check("instruction1", instruction1, e.i1);
        check("instruction2", instruction2, e.i2);
      end
    end
  end

  initial begin
    int first_v;
    int lat;
    logic [31:0] tgt;
    rst_n = 1'b0; ls_gnt = 1'b0; ls_rvalid = 1'b0; ls_rdata = 64'h0;
    branch_taken = 1'b0; branch_target = 32'h0; stall = 1'b0;

    do_reset();
    mon_en = 1'b1;

    // Free run from reset: grant every cycle, one-cycle read latency.
    first_v = -1;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 32'h0, 1'b0);
      if (last_fv && first_v < 0) first_v = i;
    end
    check("reset_to_first_valid", 32'(first_v), 32'd2);

    // Five stall cycles fill credit; head must hold.
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1);
    check("stall_credit_exhausted", {31'b0, ls_req}, 32'h0);
    check("stall_head_valid", {31'b0, fetch_valid}, 32'h1);
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b0);

    // Redirect into the odd word of a pair while a grant and a response are both live.
    step(1'b1, 32'h204, 1'b0);
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      step(1'b0, 32'h0, 1'b0);
      if (last_fv) begin lat = i; break; end
    end
    check("redirect_latency", 32'(lat), 32'd3);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b0);

    // Several reads outstanding, then redirect to 0x100.
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h100, 1'b0);
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b0);

    // Address wrap at the top of the PC space.
    step(1'b1, 32'hFFFF_FFF0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b0);

    // Randomized traffic with a reset in the middle.
    gnt_pct = 70; lat_min = 1; lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      if ($urandom_range(99) < 4) begin
        tgt = $urandom();
        if ($urandom_range(3) == 0) tgt = 32'hFFFF_FFE0 | (tgt & 32'h1F);
        step(1'b1, tgt, $urandom_range(99) < 25);
      end else begin
        step(1'b0, 32'h0, $urandom_range(99) < 25);
      end
    end

    // Drain.
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    for (int i = 0; i < 20; i++) step(1'b0, 32'h0, 1'b0);
    check("made_progress", {31'b0, pops >= 800}, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
